// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt dispatcher: delivery state encoding,
// the "no interrupt" ID and a constant-foldable ceil(log2) used for port widths.
package irq_pkg;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_BUSY = 1'b1
  } irq_state_t;

  localparam int ID_NONE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_fifo.sv
// Synchronous DEPTH x W queue of pending interrupt IDs; head is visible on dout
// without a read latency. Pushes when full and pops when empty are ignored.
module irq_fifo import irq_pkg::*; #(
  parameter int W     = 3,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/irq_dispatch.sv
// Interrupt front-end: edge capture, arbitration into an ID queue, and one-at-a-time
// delivery to the core. Define IRQ_RR_EN for round-robin arbitration (default: fixed priority).
module irq_dispatch import irq_pkg::*; #(
  parameter int N_IRQ = 7,
  parameter int ID_W  = 3,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq,
  input  logic [N_IRQ-1:0]      irq_en,
  input  logic                  eirq,
  output logic [ID_W-1:0]       irq_id,
  output logic                  irq_strobe,
  output logic                  busy,
  output logic [clog2(DEPTH):0] fifo_count,
  output logic                  lost
);

  localparam int IDX_W = (clog2(N_IRQ) > 0) ? clog2(N_IRQ) : 1;

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] irq_edge;
  logic [N_IRQ-1:0] grant_mask;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] idx;
  logic [ID_W-1:0]  push_id;
  logic [ID_W-1:0]  head;
  logic             full;
  logic             empty;
  logic             pop;
  irq_state_t       state;
  irq_state_t       state_n;
  logic [ID_W-1:0]  id_n;
  logic             strobe_n;

`ifdef IRQ_RR_EN
  logic [IDX_W-1:0] rr_ptr;
`endif

  assign irq_edge = irq & ~irq_q & irq_en;
  assign push_id  = ID_W'(grant_idx) + ID_W'(1);
  assign busy     = (state == IRQ_BUSY);

  // Descending scan with last-hit-wins gives the first candidate the highest priority.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_mask = '0;
    idx        = '0;
    if (!full) begin
      for (int i = N_IRQ - 1; i >= 0; i--) begin
`ifdef IRQ_RR_EN
        idx = IDX_W'((int'(rr_ptr) + i) % N_IRQ);
`else
        idx = IDX_W'(i);
`endif
        if (pending[idx]) begin
          grant_vld = 1'b1;
          grant_idx = idx;
        end
      end
      if (grant_vld) grant_mask[grant_idx] = 1'b1;
    end
  end

  // Edge set takes precedence over the grant clear on the same line.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      lost    <= 1'b0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~grant_mask) | irq_edge;
      lost    <= lost | (|(irq_edge & pending));
    end
  end

`ifdef IRQ_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == IDX_W'(N_IRQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end
`endif

  irq_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant_vld),
    .pop   (pop),
    .din   (push_id),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    id_n     = irq_id;
    strobe_n = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          id_n     = head;
          strobe_n = 1'b1;
          state_n  = IRQ_BUSY;
        end
      end
      IRQ_BUSY: begin
        if (eirq) begin
          if (!empty) begin
            pop      = 1'b1;
            id_n     = head;
            strobe_n = 1'b1;
          end else begin
            id_n    = ID_W'(ID_NONE);
            state_n = IRQ_IDLE;
          end
        end
      end
      default: state_n = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IRQ_IDLE;
      irq_id     <= ID_W'(ID_NONE);
      irq_strobe <= 1'b0;
    end else begin
      state      <= state_n;
      irq_id     <= id_n;
      irq_strobe <= strobe_n;
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Directed bench for irq_dispatch (N_IRQ=7, ID_W=3, DEPTH=4): latency, ordering,
// queue saturation, merged edges, enable masking and mid-operation reset.
module tb_irq_dispatch;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] irq;
  logic [6:0] irq_en;
  logic       eirq;
  logic [2:0] irq_id;
  logic       irq_strobe;
  logic       busy;
  logic [2:0] fifo_count;
  logic       lost;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_dispatch #(
    .N_IRQ (7),
    .ID_W  (3),
    .DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .irq_en     (irq_en),
    .eirq       (eirq),
    .irq_id     (irq_id),
    .irq_strobe (irq_strobe),
    .busy       (busy),
    .fifo_count (fifo_count),
    .lost       (lost)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic deliver_next(input string tag, input int exp_id);
    eirq = 1'b1;
    tick();
    eirq = 1'b0;
    chk({tag, "_strobe"}, irq_strobe, 1);
    chk({tag, "_id"}, irq_id, exp_id);
    chk({tag, "_busy"}, busy, 1);
    tick();
    chk({tag, "_strobe_low"}, irq_strobe, 0);
  endtask

  task automatic finish_idle(input string tag);
    eirq = 1'b1;
    tick();
    eirq = 1'b0;
    chk({tag, "_id0"}, irq_id, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst    = 1'b1;
    irq    = '0;
    irq_en = '1;
    eirq   = 1'b0;
    tick();
    tick();
    chk("rst_id", irq_id, 0);
    chk("rst_strobe", irq_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_lost", lost, 0);
    rst = 1'b0;

    // Single request on line 2: pending at N, queued at N+1, issued at N+2.
    irq = 7'b0000100;
    tick();
    chk("t1_n_count", fifo_count, 0);
    chk("t1_n_strobe", irq_strobe, 0);
    tick();
    chk("t1_n1_count", fifo_count, 1);
    chk("t1_n1_busy", busy, 0);
    tick();
    chk("t1_n2_strobe", irq_strobe, 1);
    chk("t1_n2_id", irq_id, 3);
    chk("t1_n2_busy", busy, 1);
    chk("t1_n2_count", fifo_count, 0);
    tick();
    chk("t1_hold_strobe", irq_strobe, 0);
    chk("t1_hold_id", irq_id, 3);
    irq = '0;
    finish_idle("t1_eoi");

    // Simultaneous edges on lines 0, 4, 6 with fixed priority.
    irq = 7'b1010001;
    tick();
    tick();
    tick();
    chk("t2_first_strobe", irq_strobe, 1);
    chk("t2_first_id", irq_id, 1);
    tick();
    chk("t2_count", fifo_count, 2);
    deliver_next("t2_second", 5);
    deliver_next("t2_third", 7);
    finish_idle("t2_eoi");
    irq = '0;
    tick();

`ifdef IRQ_RR_EN
    // Grant line 4 alone so the search next starts at line 5.
    irq = 7'b0010000;
    tick();
    tick();
    tick();
    chk("rr_prime_id", irq_id, 5);
    finish_idle("rr_prime_eoi");
    irq = '0;
    tick();
    irq = 7'b1010001;
    tick();
    tick();
    tick();
    chk("rr_first_id", irq_id, 7);
    deliver_next("rr_second", 1);
    deliver_next("rr_third", 5);
    finish_idle("rr_eoi");
    irq = '0;
    tick();
`endif

    // All seven lines with no eirq: one busy, four queued, two held pending.
    irq = 7'b1111111;
    for (int i = 0; i < 7; i++) tick();
    chk("ovf_count_sat", fifo_count, 4);
    chk("ovf_busy_id", irq_id, 1);
    tick();
    tick();
    chk("ovf_count_hold", fifo_count, 4);
    chk("ovf_lost", lost, 0);
    deliver_next("ovf_2", 2);
    chk("ovf_refill", fifo_count, 4);
    deliver_next("ovf_3", 3);
    deliver_next("ovf_4", 4);
    deliver_next("ovf_5", 5);
    deliver_next("ovf_6", 6);
    deliver_next("ovf_7", 7);
    finish_idle("ovf_eoi");
    chk("ovf_lost_end", lost, 0);
    irq = '0;
    tick();

    // Fill the queue with lines 2..6, then pulse line 1 twice before it can be granted.
    irq = 7'b1111100;
    for (int i = 0; i < 6; i++) tick();
    chk("rep_full", fifo_count, 4);
    irq = 7'b1111110;
    tick();
    chk("rep_first_lost", lost, 0);
    irq = 7'b1111100;
    tick();
    irq = 7'b1111110;
    tick();
    chk("rep_lost", lost, 1);
    chk("rep_count", fifo_count, 4);
    deliver_next("rep_4", 4);
    deliver_next("rep_5", 5);
    deliver_next("rep_6", 6);
    deliver_next("rep_7", 7);
    deliver_next("rep_2", 2);
    finish_idle("rep_eoi");
    chk("rep_lost_sticky", lost, 1);
    irq = '0;
    tick();

    // Busy with three queued, then reset.
    irq = 7'b0001111;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_count", fifo_count, 3);
    chk("mid_busy", busy, 1);
    chk("mid_id", irq_id, 1);
    rst = 1'b1;
    irq = '0;
    tick();
    rst = 1'b0;
    chk("mid_rst_id", irq_id, 0);
    chk("mid_rst_strobe", irq_strobe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_lost", lost, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_strobe", irq_strobe, 0);
      chk("post_rst_busy", busy, 0);
    end

    // A disabled line never becomes pending.
    irq_en = 7'b1110111;
    irq    = 7'b0001000;
    for (int i = 0; i < 4; i++) tick();
    chk("dis_busy", busy, 0);
    chk("dis_count", fifo_count, 0);
    chk("dis_id", irq_id, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
